// File: rtl/midi_tx_pkg.sv
// Shared MIDI constants and payload type for the MIDI TX path.
// Global defaults are defined here once, guarded so an upstream header can override them.
`ifndef F_CLK_HZ
`define F_CLK_HZ 10_000_000
`endif
`ifndef F_BAUD
`define F_BAUD 31_250
`endif
`ifndef MIDI_PAYLOAD_BITS
`define MIDI_PAYLOAD_BITS 8
`endif
`ifndef MIDI_STOP_BITS
`define MIDI_STOP_BITS 1
`endif

package midi_tx_pkg;
    localparam int PAYLOAD_BITS = `MIDI_PAYLOAD_BITS;
    localparam int FRAME_BITS   = 1 + PAYLOAD_BITS + `MIDI_STOP_BITS;

    typedef logic [PAYLOAD_BITS-1:0] midiByte_t;
endpackage

// File: rtl/midi_tx_fifo.sv
// Purpose: small synchronous FIFO buffering bytes ahead of the MIDI serialiser.
// Latency: a pushed entry is visible on popData_o the cycle after the push edge.
// Backpressure: pushes are ignored while full_o, pops while empty_o; no full-state bypass.
module midi_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             nrst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] pushData_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] popData_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wrPtr;
    logic [AW:0]      rdPtr;

    // Extra MSB on each pointer tells full from empty when the indices match.
    assign empty_o   = (wrPtr == rdPtr);
    assign full_o    = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
    assign popData_o = mem[rdPtr[AW-1:0]];

    always_ff @(posedge clk_i) begin
        if (!nrst_i) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (push_i && !full_o) wrPtr <= wrPtr + (AW+1)'(1);
            if (pop_i && !empty_o) rdPtr <= rdPtr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i && !full_o) mem[wrPtr[AW-1:0]] <= pushData_i;
    end
endmodule

// File: rtl/midi_tx.sv
// Purpose: MIDI 8N1 serial transmitter, LSB first, idle high; MIDI_TX_FIFO_EN adds an input FIFO.
// Latency: start bit driven on the accept edge (one cycle later via the FIFO); frame = 10 bit times.
// Backpressure: txReady_o only in IDLE without the FIFO, otherwise while the FIFO is not full.
module midi_tx
    import midi_tx_pkg::*;
#(
    parameter int CYCLES_PER_BIT = `F_CLK_HZ / `F_BAUD,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                          clk_i,
    input  logic                          nrst_i,
    input  logic                          txValid_i,
    input  logic [`MIDI_PAYLOAD_BITS-1:0] txByte_i,
    output logic                          txReady_o,
    output logic                          txData_o,
    output logic                          busy_o
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    localparam int              CW       = $clog2(CYCLES_PER_BIT);
    localparam logic [CW-1:0]   CYC_LAST = CW'(CYCLES_PER_BIT - 1);
    localparam int              BW       = $clog2(PAYLOAD_BITS);
    localparam logic [BW-1:0]   BIT_LAST = BW'(PAYLOAD_BITS - 1);

    if (CYCLES_PER_BIT < 2 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : gBadParams
        $error("midi_tx: CYCLES_PER_BIT must be >= 2 and FIFO_DEPTH a power of two >= 2");
    end

    logic [1:0]    state;
    logic [1:0]    nextState;
    logic [CW-1:0] cycleCounter;
    logic [BW-1:0] bitCounter;
    midiByte_t     shiftReg;
    midiByte_t     frameByte;
    logic          busyReg;
    logic          startFrame;
    logic          cycleEnd;

    assign cycleEnd = (cycleCounter == CYC_LAST);

`ifdef MIDI_TX_FIFO_EN
    logic fifoFull;
    logic fifoEmpty;

    // Pop edge is the START-entry edge, so the popped byte is latched as it leaves.
    midi_tx_fifo #(
        .WIDTH (PAYLOAD_BITS),
        .DEPTH (FIFO_DEPTH)
    ) uFifo (
        .clk_i      (clk_i),
        .nrst_i     (nrst_i),
        .push_i     (txValid_i),
        .pushData_i (txByte_i),
        .pop_i      (startFrame),
        .popData_o  (frameByte),
        .full_o     (fifoFull),
        .empty_o    (fifoEmpty)
    );

    assign startFrame = (state == IDLE) && !fifoEmpty;
`else
    assign startFrame = (state == IDLE) && txValid_i;
    assign frameByte  = txByte_i;
`endif

    always_ff @(posedge clk_i) begin
        if (!nrst_i) begin
            state   <= IDLE;
            busyReg <= 1'b0;
        end else begin
            state   <= nextState;
            busyReg <= (nextState != IDLE);
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (startFrame) nextState = START;
            START:   if (cycleEnd) nextState = DATA;
            DATA:    if (cycleEnd && bitCounter == BIT_LAST) nextState = STOP;
            STOP:    if (cycleEnd) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
`ifdef MIDI_TX_FIFO_EN
        txReady_o = !fifoFull;
        busy_o    = busyReg || !fifoEmpty;
`else
        txReady_o = (state == IDLE);
        busy_o    = busyReg;
`endif
    end

    always_ff @(posedge clk_i) begin
        if (!nrst_i) begin
            txData_o     <= 1'b1;
            cycleCounter <= '0;
            bitCounter   <= '0;
            shiftReg     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cycleCounter <= '0;
                    bitCounter   <= '0;
                    txData_o     <= 1'b1;
                    if (startFrame) begin
                        shiftReg <= frameByte;
                        txData_o <= 1'b0;
                    end
                end
                START: begin
                    if (cycleEnd) begin
                        cycleCounter <= '0;
                        txData_o     <= shiftReg[0];
                    end else begin
                        cycleCounter <= cycleCounter + CW'(1);
                    end
                end
                DATA: begin
                    if (cycleEnd) begin
                        cycleCounter <= '0;
                        shiftReg     <= shiftReg >> 1;
                        // bitCounter holds at the last bit rather than wrapping.
                        if (bitCounter == BIT_LAST) begin
                            txData_o <= 1'b1;
                        end else begin
                            bitCounter <= bitCounter + BW'(1);
                            txData_o   <= shiftReg[1];
                        end
                    end else begin
                        cycleCounter <= cycleCounter + CW'(1);
                    end
                end
                STOP: begin
                    txData_o <= 1'b1;
                    if (cycleEnd) cycleCounter <= '0;
                    else          cycleCounter <= cycleCounter + CW'(1);
                end
                default: begin
                    cycleCounter <= '0;
                    bitCounter   <= '0;
                    txData_o     <= 1'b1;
                end
            endcase
        end
    end
endmodule
